// File: rtl/uart_pkg.sv
// Shared types and constants for the parameterised UART receiver.
// Holds the parity mode enum, the receive FSM states and the oversample ratio.
package uart_pkg;

    localparam int OVS = 16;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == DEPTH_V);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; emptiness is tracked by count,
    // and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver: 16x oversampling, 3-sample majority vote, optional parity, receive FIFO.
// Define UART_RX_BREAK_DET_EN to report all-zero frames on break_det instead of frame_error.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 72_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rx,
    output logic [DATA_BITS-1:0]           data_out,
    output logic                           valid,
    input  logic                           ready,
    output logic                           frame_error,
    output logic                           parity_error,
    output logic                           overrun_error,
    output logic                           break_det,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

    localparam int             TICK_DIV  = CLK_FREQ_HZ / (BAUD_RATE * OVS);
    localparam int             DIV_W     = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam parity_e        PAR_MODE  = parity_e'(PARITY);
    localparam logic [3:0]     LAST_TICK = 4'(OVS - 1);
    localparam logic [3:0]     SMP_A     = 4'd7;
    localparam logic [3:0]     SMP_B     = 4'd8;
    localparam logic [3:0]     VOTE_TICK = 4'd9;
    localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);

    if (TICK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_rx_param: illegal parameter set (TICK_DIV must be >= 2)");
    end

    rx_state_e            state, state_n;
    logic                 rx_meta, rx_sync, rx_prev;
    logic [DIV_W-1:0]     div_cnt;
    logic [3:0]           tick_idx;
    logic                 tick, vote_now, vote, fall;
    logic                 smp_a, smp_b;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [3:0]           bit_cnt, bit_cnt_n;
    logic [3:0]           hi_cnt, hi_cnt_n;
    logic                 par_fault, par_fault_n;
    logic                 frm_fault, frm_fault_n;
    logic                 saw_one, saw_one_n;
    logic                 par_exp;
    logic                 push, pop, fifo_full, fifo_empty;
    logic                 frame_err_n, parity_err_n;
`ifdef UART_RX_BREAK_DET_EN
    logic                 break_n;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall     = rx_prev & ~rx_sync;
    assign tick     = (state != ST_IDLE) && (div_cnt == DIV_LAST);
    assign vote_now = tick && (tick_idx == VOTE_TICK);
    assign vote     = maj3(smp_a, smp_b, rx_sync);
    assign par_exp  = (PAR_MODE == ODD) ? ~^shreg : ^shreg;

    // The tick phase is held at zero while idle, so a detected edge starts a bit at tick 0.
    always_ff @(posedge clk) begin
        if (!rst_n || state == ST_IDLE) begin
            div_cnt  <= '0;
            tick_idx <= '0;
        end else if (tick) begin
            div_cnt  <= '0;
            tick_idx <= (tick_idx == LAST_TICK) ? 4'd0 : tick_idx + 4'd1;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smp_a <= 1'b1;
            smp_b <= 1'b1;
        end else if (tick) begin
            if (tick_idx == SMP_A) smp_a <= rx_sync;
            if (tick_idx == SMP_B) smp_b <= rx_sync;
        end
    end

    // NOTE: every variable gets its default before the case so no path infers a latch.
    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        bit_cnt_n    = bit_cnt;
        hi_cnt_n     = hi_cnt;
        par_fault_n  = par_fault;
        frm_fault_n  = frm_fault;
        saw_one_n    = saw_one;
        push         = 1'b0;
        frame_err_n  = 1'b0;
        parity_err_n = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        break_n      = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (fall) state_n = ST_START;
            end
            ST_START: begin
                if (vote_now) begin
                    if (vote) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n     = ST_DATA;
                        bit_cnt_n   = '0;
                        par_fault_n = 1'b0;
                        frm_fault_n = 1'b0;
                        saw_one_n   = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (vote_now) begin
                    shreg_n   = {vote, shreg[DATA_BITS-1:1]};
                    saw_one_n = saw_one | vote;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_n = '0;
                        state_n   = (PAR_MODE == NONE) ? ST_STOP : ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (vote_now) begin
                    par_fault_n = (vote != par_exp);
                    saw_one_n   = saw_one | vote;
                    state_n     = ST_STOP;
                end
            end
            ST_STOP: begin
                if (vote_now) begin
                    frm_fault_n = frm_fault | ~vote;
                    saw_one_n   = saw_one | vote;
                    bit_cnt_n   = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_STOP) begin
                        state_n = ST_IDLE;
`ifdef UART_RX_BREAK_DET_EN
                        // A break is a line condition, so it suppresses the data-level errors too.
                        if (!saw_one_n) begin
                            break_n  = 1'b1;
                            hi_cnt_n = '0;
                            state_n  = ST_BREAK;
                        end else
`endif
                        if (frm_fault_n || par_fault_n) begin
                            frame_err_n  = frm_fault_n;
                            parity_err_n = par_fault_n;
                        end else begin
                            push = 1'b1;
                        end
                    end
                end
            end
            ST_BREAK: begin
                if (tick) begin
                    if (!rx_sync)                    hi_cnt_n = '0;
                    else if (hi_cnt == LAST_TICK)    state_n  = ST_IDLE;
                    else                             hi_cnt_n = hi_cnt + 4'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: state registers take non-blocking assignments only; the comb block above uses blocking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            hi_cnt        <= '0;
            par_fault     <= 1'b0;
            frm_fault     <= 1'b0;
            saw_one       <= 1'b0;
            frame_error   <= 1'b0;
            parity_error  <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            state         <= state_n;
            shreg         <= shreg_n;
            bit_cnt       <= bit_cnt_n;
            hi_cnt        <= hi_cnt_n;
            par_fault     <= par_fault_n;
            frm_fault     <= frm_fault_n;
            saw_one       <= saw_one_n;
            frame_error   <= frame_err_n;
            parity_error  <= parity_err_n;
            overrun_error <= push && fifo_full && !pop;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    always_ff @(posedge clk) begin
        if (!rst_n) break_det <= 1'b0;
        else        break_det <= break_n;
    end
`else
    assign break_det = 1'b0;
`endif

    assign valid = !fifo_empty;
    assign pop   = valid && ready;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .pop_data  (data_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and an 8E1 instance at 16 clocks per tick.
// Received bytes are checked against a per-instance scoreboard queue.
module tb_uart_rx_param;

    localparam int CLK_HZ  = 29_491_200;
    localparam int BAUD    = 115_200;
    localparam int BIT_CYC = 256;
    localparam int CW      = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx0 = 1'b1, rx1 = 1'b1;
    logic          ready0 = 1'b0, ready1 = 1'b0;
    logic [7:0]    data0, data1;
    logic          valid0, valid1;
    logic          fe0, pe0, oe0, bd0, fe1, pe1, oe1, bd1;
    logic [CW-1:0] cnt0, cnt1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int frame_start = 0;
    int valid_rise0 = 0;
    int valid_hi0 = 0, valid_hi1 = 0;
    int fe_n0 = 0, pe_n0 = 0, oe_n0 = 0, bd_n0 = 0;
    int fe_n1 = 0, pe_n1 = 0, oe_n1 = 0, bd_n1 = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .data_out(data0), .valid(valid0),
        .ready(ready0), .frame_error(fe0), .parity_error(pe0),
        .overrun_error(oe0), .break_det(bd0), .fifo_count(cnt0)
    );

    uart_rx_param #(
        .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
    ) dut_par (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .data_out(data1), .valid(valid1),
        .ready(ready1), .frame_error(fe1), .parity_error(pe1),
        .overrun_error(oe1), .break_det(bd1), .fifo_count(cnt1)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: counts pulse cycles and pops the scoreboard on every accepted byte.
    initial begin
        logic [7:0] e;
        logic       valid0_d;
        valid0_d = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                valid0_d = 1'b0;
            end else begin
                fe_n0 += int'(fe0); pe_n0 += int'(pe0); oe_n0 += int'(oe0); bd_n0 += int'(bd0);
                fe_n1 += int'(fe1); pe_n1 += int'(pe1); oe_n1 += int'(oe1); bd_n1 += int'(bd1);
                valid_hi0 += int'(valid0);
                valid_hi1 += int'(valid1);
                if (valid0 && !valid0_d) valid_rise0 = cyc;
                valid0_d = valid0;
                if (valid0 && ready0) begin
                    checks++;
                    if (exp_q0.size() == 0) begin
                        failures++;
                        $display("FAIL pop0_unexpected: data_out=%h, required no byte", data0);
                    end else begin
                        e = exp_q0.pop_front();
                        if (data0 !== e) begin
                            failures++;
                            $display("FAIL pop0_data: data_out=%h, required %h", data0, e);
                        end
                    end
                end
                if (valid1 && ready1) begin
                    checks++;
                    if (exp_q1.size() == 0) begin
                        failures++;
                        $display("FAIL pop1_unexpected: data_out=%h, required no byte", data1);
                    end else begin
                        e = exp_q1.pop_front();
                        if (data1 !== e) begin
                            failures++;
                            $display("FAIL pop1_data: data_out=%h, required %h", data1, e);
                        end
                    end
                end
            end
        end
    end

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx1 = v;
        else     rx0 = v;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] data,
                              input bit with_par, input logic par_bit);
        logic [10:0] bits;
        int          nbits;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = data;
        nbits     = 10;
        if (with_par) begin
            bits[9] = par_bit;
            nbits   = 11;
        end
        frame_start = cyc;
        for (int i = 0; i < nbits; i++) begin
            set_rx(sel, bits[i]);
            wait_cycles(BIT_CYC);
        end
    endtask

    task automatic wait_drain(input bit sel, input string name);
        int n;
        n = 0;
        while (((sel ? exp_q1.size() : exp_q0.size()) != 0) && n < 4 * BIT_CYC) begin
            wait_cycles(1);
            n++;
        end
        checks++;
        if ((sel ? exp_q1.size() : exp_q0.size()) != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d bytes still outstanding, required 0", name,
                     sel ? exp_q1.size() : exp_q0.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cycles(5);
        @(negedge clk);
        checks += 7;
        if (valid0 !== 1'b0)  begin failures++; $display("FAIL reset_valid: %b, required 0", valid0); end
        if (cnt0 !== '0)      begin failures++; $display("FAIL reset_count: %0d, required 0", cnt0); end
        if (data0 !== 8'h00)  begin failures++; $display("FAIL reset_data: %h, required 00", data0); end
        if ({fe0, pe0, oe0, bd0} !== 4'b0000)
            begin failures++; $display("FAIL reset_errors: %b, required 0000", {fe0, pe0, oe0, bd0}); end
        if (valid1 !== 1'b0)  begin failures++; $display("FAIL reset_valid1: %b, required 0", valid1); end
        if (cnt1 !== '0)      begin failures++; $display("FAIL reset_count1: %0d, required 0", cnt1); end
        if ({fe1, pe1, oe1, bd1} !== 4'b0000)
            begin failures++; $display("FAIL reset_errors1: %b, required 0000", {fe1, pe1, oe1, bd1}); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cycles(10);
    endtask

    task automatic test_single_byte();
        logic [7:0] pat [4];
        int         fe_s, pe_s, oe_s, lat;
        pat = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
        fe_s = fe_n0; pe_s = pe_n0; oe_s = oe_n0;
        ready0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q0.push_back(pat[i]);
            send_frame(1'b0, pat[i], 1'b0, 1'b0);
            lat = valid_rise0 - frame_start;
            checks++;
            // Stop-bit vote lands 9 bits + 10 ticks after the edge, plus a few sync cycles.
            if (lat < 2460 || lat > 2475) begin
                failures++;
                $display("FAIL byte_latency: byte %h valid after %0d cycles, required 2460..2475", pat[i], lat);
            end
        end
        wait_drain(1'b0, "byte");
        checks += 3;
        if (fe_n0 != fe_s) begin failures++; $display("FAIL byte_frame_err: %0d pulses, required 0", fe_n0 - fe_s); end
        if (pe_n0 != pe_s) begin failures++; $display("FAIL byte_parity_err: %0d pulses, required 0", pe_n0 - pe_s); end
        if (oe_n0 != oe_s) begin failures++; $display("FAIL byte_overrun: %0d pulses, required 0", oe_n0 - oe_s); end
    endtask

    task automatic test_parity();
        int pe_s, fe_s;
        pe_s = pe_n1; fe_s = fe_n1;
        ready1 = 1'b1;
        exp_q1.push_back(8'h3C);
        send_frame(1'b1, 8'h3C, 1'b1, 1'b0);
        wait_drain(1'b1, "parity_good");
        send_frame(1'b1, 8'h3C, 1'b1, 1'b1);
        wait_cycles(300);
        checks += 4;
        if (pe_n1 - pe_s != 1) begin failures++; $display("FAIL parity_pulse: %0d pulses, required 1", pe_n1 - pe_s); end
        if (fe_n1 != fe_s)     begin failures++; $display("FAIL parity_frame_err: %0d pulses, required 0", fe_n1 - fe_s); end
        if (cnt1 !== '0)       begin failures++; $display("FAIL parity_count: %0d, required 0", cnt1); end
        if (exp_q1.size() != 0) begin failures++; $display("FAIL parity_queue: %0d left, required 0", exp_q1.size()); end
    endtask

    task automatic test_overrun();
        int oe_s, fe_s;
        oe_s = oe_n0; fe_s = fe_n0;
        ready0 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q0.push_back(8'(i));
            send_frame(1'b0, 8'(i), 1'b0, 1'b0);
        end
        wait_cycles(300);
        checks += 3;
        if (cnt0 !== 5'd16)     begin failures++; $display("FAIL overrun_count: %0d, required 16", cnt0); end
        if (oe_n0 - oe_s != 1)  begin failures++; $display("FAIL overrun_pulse: %0d pulses, required 1", oe_n0 - oe_s); end
        if (fe_n0 != fe_s)      begin failures++; $display("FAIL overrun_frame_err: %0d pulses, required 0", fe_n0 - fe_s); end
        ready0 = 1'b1;
        wait_drain(1'b0, "overrun");
        wait_cycles(2);
        checks++;
        if (cnt0 !== '0) begin failures++; $display("FAIL overrun_empty: count %0d, required 0", cnt0); end
    endtask

    task automatic test_glitch();
        int vh_s, fe_s, pe_s;
        vh_s = valid_hi0; fe_s = fe_n0; pe_s = pe_n0;
        rx0 = 1'b0;
        wait_cycles(BIT_CYC / 4);
        rx0 = 1'b1;
        wait_cycles(2 * BIT_CYC);
        checks += 3;
        if (valid_hi0 != vh_s) begin failures++; $display("FAIL glitch_valid: %0d valid cycles, required 0", valid_hi0 - vh_s); end
        if (fe_n0 != fe_s)     begin failures++; $display("FAIL glitch_frame_err: %0d pulses, required 0", fe_n0 - fe_s); end
        if (pe_n0 != pe_s)     begin failures++; $display("FAIL glitch_parity_err: %0d pulses, required 0", pe_n0 - pe_s); end
        exp_q0.push_back(8'h55);
        send_frame(1'b0, 8'h55, 1'b0, 1'b0);
        wait_drain(1'b0, "glitch");
    endtask

    task automatic test_break();
        int fe_s, bd_s;
        fe_s = fe_n0; bd_s = bd_n0;
        rx0 = 1'b0;
        wait_cycles(12 * BIT_CYC);
        rx0 = 1'b1;
        wait_cycles(2 * BIT_CYC);
        checks += 3;
`ifdef UART_RX_BREAK_DET_EN
        if (bd_n0 - bd_s != 1) begin failures++; $display("FAIL break_pulse: %0d pulses, required 1", bd_n0 - bd_s); end
        if (fe_n0 != fe_s)     begin failures++; $display("FAIL break_frame_err: %0d pulses, required 0", fe_n0 - fe_s); end
`else
        if (fe_n0 - fe_s != 1) begin failures++; $display("FAIL break_frame_err: %0d pulses, required 1", fe_n0 - fe_s); end
        if (bd_n0 != bd_s)     begin failures++; $display("FAIL break_pulse: %0d pulses, required 0", bd_n0 - bd_s); end
`endif
        if (cnt0 !== '0) begin failures++; $display("FAIL break_count: %0d, required 0", cnt0); end
        exp_q0.push_back(8'h5A);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0);
        wait_drain(1'b0, "break");
    endtask

    task automatic test_reset_midframe();
        int vh_s;
        vh_s = valid_hi0;
        ready0 = 1'b1;
        rx0 = 1'b0;
        wait_cycles(BIT_CYC);
        rx0 = 1'b1;
        wait_cycles(3 * BIT_CYC + BIT_CYC / 2);
        rst_n = 1'b0;
        wait_cycles(1);
        rst_n = 1'b1;
        wait_cycles(BIT_CYC / 2 - 1 + 5 * BIT_CYC);
        checks += 2;
        if (valid_hi0 != vh_s) begin failures++; $display("FAIL midreset_valid: %0d valid cycles, required 0", valid_hi0 - vh_s); end
        if (cnt0 !== '0)       begin failures++; $display("FAIL midreset_count: %0d, required 0", cnt0); end
        exp_q0.push_back(8'h81);
        send_frame(1'b0, 8'h81, 1'b0, 1'b0);
        wait_drain(1'b0, "midreset");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_parity();
        test_overrun();
        test_glitch();
        test_break();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
